pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined integer add/subtract unit for the EX datapath.
//  Carry chain is split into STAGES segments; each segment is registered, so timing scales with WIDTH/STAGES.
//  Subtract is a + ~b + 1, so cout=1 means no borrow. Results carry C/V/Z/N flags for branch compare and SLT logic.
//  Valid/ready on both sides; the whole pipe stalls as one unit.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; must be >= 2
//  STAGES  4   pipeline segments (= latency in cycles); WIDTH % STAGES == 0; 1 allowed
// PORTS
//  i_clk      in   1      clock, rising edge
//  i_rst_n    in   1      asynchronous active-low reset
//  i_flush    in   1      synchronous kill of all in-flight ops
//  i_valid    in   1      input op valid
//  o_ready    out  1      unit accepts op this cycle
//  i_sub      in   1      0: a+b, 1: a-b
//  i_a        in   WIDTH  operand a
//  i_b        in   WIDTH  operand b
//  o_valid    out  1      result valid
//  i_ready    in   1      downstream accepts result
//  o_s        out  WIDTH  result
//  o_cout     out  1      carry out of MSB (sub: 1 = no borrow)
//  o_ovf      out  1      signed overflow
//  o_zero     out  1      o_s == 0
//  o_neg      out  1      o_s[WIDTH-1]
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): all stage valids, data, carries and all outputs = 0. o_ready is combinational and therefore reads 1 during reset.
//  - Advance: adv = !o_valid | i_ready. o_ready = adv. Handshake in: i_valid & o_ready; out: o_valid & i_ready.
//  - While adv=0, every stage holds its contents and i_valid is ignored (o_ready=0).
//  - Segment k (k=0..STAGES-1) covers bits [k*SEG +: SEG], where SEG = WIDTH/STAGES.
//    Stage 0 adds segment 0 with cin = i_sub. Stage k adds segment k with the registered carry from stage k-1.
//    Operand segments not yet consumed are carried down the pipe, skewed by one stage per segment.
//    Result segments already produced are carried down alongside them.
//  - Latency: exactly STAGES cycles from input handshake to o_valid, with no stall.
//    Throughput 1 op/cycle. Back-to-back ops never interfere.
//  - o_cout = carry out of segment STAGES-1.
//    o_ovf = (a_msb ~^ b_eff_msb) & (s_msb ^ a_msb), where b_eff = i_sub ? ~b : b.
//  - o_zero and o_neg are derived from the final o_s.
//  - All outputs are registered and held stable while o_valid=1 & i_ready=0.
//  - i_flush=1: all stage valids clear on the next edge. An op offered in the same cycle is dropped, even if o_ready=1.
//    Data registers may keep stale values. Flush overrides stall.
//  - Wrap-around: arithmetic is modulo 2^WIDTH.
//  - Reset mid-operation: in-flight ops are lost. The first op after release has full latency.
// CONFIGURATION
//  - ADDSUB_SAT_EN defined: on o_ovf=1, o_s is clamped to signed saturation.
//    Overflow with positive a gives 0x7FF..F; with negative a it gives 0x800..0.
//    o_ovf and o_cout still report the raw result. o_zero and o_neg follow the clamped o_s.
//    Clamp is applied in the last stage; latency is unchanged.
//  - ADDSUB_SAT_EN undefined: o_s is the raw wrapped result. No clamp logic is present.
// TESTING
//  1. WIDTH=32, STAGES=4, a=5, b=3, sub=1 -> after 4 cycles o_s=2, cout=1, ovf=0, zero=0, neg=0.
//  2. a=0, b=1, sub=1 -> o_s=0xFFFFFFFF, cout=0, neg=1. Then a=0xFFFFFFFF, b=1, add -> o_s=0, cout=1, zero=1.
//     This also checks a carry crossing every segment.
//  3. a=0x7FFFFFFF, b=1, add -> ovf=1.
//     Without macro: o_s=0x80000000. With ADDSUB_SAT_EN: o_s=0x7FFFFFFF, neg=0.
//     Also a=0x80000000, b=1, sub -> sat o_s=0x80000000.
//  4. Stream 8 ops back-to-back. Hold i_ready=0 for 3 cycles mid-stream -> o_ready=0 during the stall.
//     Outputs stay stable; all 8 results arrive in order, with none lost or duplicated.
//  5. 3 ops in flight, pulse i_flush while offering a 4th -> no o_valid for any of the 4.
//     The next op completes normally after 4 cycles.
//  6. Assert i_rst_n=0 mid-stream -> outputs 0 immediately (async). Repeat tests 1 and 2 with STAGES=1 and STAGES=32.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with C/V/Z/N flags; the carry chain is cut into STAGES registered segments.
// Define ADDSUB_SAT_EN to clamp overflowing results to signed saturation in the last stage.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero,
    output logic             o_neg
);
    // WIDTH must be a multiple of STAGES; each stage resolves one SEG-bit slice of the sum.
    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Valid/ready: an op transfers in on i_valid & o_ready and out on o_valid & i_ready;
    // the whole pipe advances as one unit whenever the output slot is empty or being taken.
    logic adv;
    assign adv     = !o_valid || i_ready;
    assign o_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;
        localparam int RW = WIDTH - LO;

        // Only the operand bits not yet consumed travel with the op.
        logic [RW-1:0]     a_in;
        logic [RW-1:0]     b_in;
        logic              c_in;
        logic              v_in;
        logic [SEG:0]      sum;
        logic [LO+SEG-1:0] s_out;

        assign sum = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};

        if (k == 0) begin : g_head
            assign a_in  = i_a;
            assign b_in  = i_sub ? ~i_b : i_b;
            assign c_in  = i_sub;
            assign v_in  = i_valid;
            assign s_out = sum[SEG-1:0];
        end else begin : g_body
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
            logic          c_q;
            logic          v_q;
            logic [LO-1:0] s_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                    s_q <= '0;
                end else begin
                    if (i_flush) begin
                        v_q <= 1'b0;
                    end else if (adv) begin
                        v_q <= g_stage[k-1].v_in;
                    end
                    if (adv) begin
                        a_q <= g_stage[k-1].a_in[RW+SEG-1:SEG];
                        b_q <= g_stage[k-1].b_in[RW+SEG-1:SEG];
                        c_q <= g_stage[k-1].sum[SEG];
                        s_q <= g_stage[k-1].s_out;
                    end
                end
            end

            assign a_in  = a_q;
            assign b_in  = b_q;
            assign c_in  = c_q;
            assign v_in  = v_q;
            assign s_out = {sum[SEG-1:0], s_q};
        end
    end

    logic [WIDTH-1:0] raw_s;
    logic [WIDTH-1:0] fin_s;
    logic             a_msb;
    logic             b_msb;
    logic             fin_ovf;

    assign raw_s   = g_stage[LAST].s_out;
    assign a_msb   = g_stage[LAST].a_in[SEG-1];
    assign b_msb   = g_stage[LAST].b_in[SEG-1];
    assign fin_ovf = (a_msb ~^ b_msb) & (raw_s[WIDTH-1] ^ a_msb);

`ifdef ADDSUB_SAT_EN
    always_comb begin
        fin_s = raw_s;
        if (fin_ovf) begin
            fin_s = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign fin_s = raw_s;
`endif

    // Last stage lands directly in the output registers, so latency equals STAGES.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_s     <= '0;
            o_cout  <= 1'b0;
            o_ovf   <= 1'b0;
            o_zero  <= 1'b0;
            o_neg   <= 1'b0;
        end else begin
            if (i_flush) begin
                o_valid <= 1'b0;
            end else if (adv) begin
                o_valid <= g_stage[LAST].v_in;
            end
            if (adv) begin
                o_s    <= fin_s;
                o_cout <= g_stage[LAST].sum[SEG];
                o_ovf  <= fin_ovf;
                o_zero <= (fin_s == '0);
                o_neg  <= fin_s[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: three instances (STAGES 4, 1, 32) sharing operand inputs.
module tb_pipelined_addsub;
  localparam int W  = 32;
  localparam int EW = W + 5;

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         flush  = 1'b0;
  logic         sub    = 1'b0;
  logic         rdy_in = 1'b1;
  logic [W-1:0] a      = '0;
  logic [W-1:0] b      = '0;

  logic         vin[3] = '{1'b0, 1'b0, 1'b0};
  logic         rdy[3];
  logic         ov[3];
  logic [W-1:0] s[3];
  logic         co[3];
  logic         ovf[3];
  logic         z[3];
  logic         n[3];
  int           lat[3] = '{4, 1, 32};

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(4)) u_s4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[0]), .o_ready(rdy[0]),
    .i_sub(sub), .i_a(a), .i_b(b), .o_valid(ov[0]), .i_ready(rdy_in), .o_s(s[0]),
    .o_cout(co[0]), .o_ovf(ovf[0]), .o_zero(z[0]), .o_neg(n[0])
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(1)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[1]), .o_ready(rdy[1]),
    .i_sub(sub), .i_a(a), .i_b(b), .o_valid(ov[1]), .i_ready(rdy_in), .o_s(s[1]),
    .o_cout(co[1]), .o_ovf(ovf[1]), .o_zero(z[1]), .o_neg(n[1])
  );

  pipelined_addsub #(.WIDTH(W), .STAGES(32)) u_s32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(vin[2]), .o_ready(rdy[2]),
    .i_sub(sub), .i_a(a), .i_b(b), .o_valid(ov[2]), .i_ready(rdy_in), .o_s(s[2]),
    .o_cout(co[2]), .o_ovf(ovf[2]), .o_zero(z[2]), .o_neg(n[2])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one op to instance d on an idle pipe, measure latency and check the result.
  task automatic run_op(input int d, input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tsub, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic ez, input logic en);
    int cyc;
    a = ta; b = tb; sub = tsub; vin[d] = 1'b1;
    @(negedge clk);
    check({tag, "_ready"}, 64'(rdy[d]), 64'd1);
    @(posedge clk); #1;
    vin[d] = 1'b0;
    cyc = 1;
    while (!ov[d] && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(lat[d]));
    check({tag, "_s"}, 64'(s[d]), 64'(es));
    check({tag, "_flags_cvzn"}, 64'({co[d], ovf[d], z[d], n[d]}), 64'({ec, eo, ez, en}));
    @(posedge clk); #1;
  endtask

  logic [W-1:0]  op_a[8];
  logic [W-1:0]  op_b[8];
  logic          op_sub[8];
  logic [EW-1:0] cur;
  logic [EW-1:0] snap;
  logic          held;
  int            cyc;
  int            sent;
  int            got;
  int            seen;

  initial begin
    // ---- reset state ----
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid_d%0d", d), 64'(ov[d]), 64'd0);
      check($sformatf("rst_out_d%0d", d), 64'({s[d], co[d], ovf[d], z[d], n[d]}), 64'd0);
      check($sformatf("rst_ready_d%0d", d), 64'(rdy[d]), 64'd1);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- basic sub/add and full carry ripple on every depth ----
    for (int d = 0; d < 3; d++) begin
      run_op(d, $sformatf("t1_d%0d", d), 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(d, $sformatf("t2a_d%0d", d), 32'd0, 32'd1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      run_op(d, $sformatf("t2b_d%0d", d), 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    end

    // ---- signed overflow ----
`ifdef ADDSUB_SAT_EN
    run_op(0, "t3a", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(0, "t3b", 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
`else
    run_op(0, "t3a", 32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
    run_op(0, "t3b", 32'h8000_0000, 32'd1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    // ---- stream of 8 with a 3-cycle output stall ----
    op_a   = '{32'd1, 32'd10, 32'd100, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd3};
    op_b   = '{32'd2, 32'd4,  32'd200, 32'd1,         32'hFFFF_FFFF, 32'd7, 32'h8000_0000, 32'd5};
    op_sub = '{1'b0,  1'b1,   1'b0,    1'b0,          1'b0,          1'b1,  1'b0,          1'b1};
    // packed as {valid, s, cout, ovf, zero, neg}
    exp_q.push_back({1'b1, 32'd3,         1'b0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 32'd6,         1'b1, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 32'd300,       1'b0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0});
    exp_q.push_back({1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, 1'b1});
    exp_q.push_back({1'b1, 32'd0,         1'b1, 1'b0, 1'b1, 1'b0});
`ifdef ADDSUB_SAT_EN
    exp_q.push_back({1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b1});
`else
    exp_q.push_back({1'b1, 32'd0,         1'b1, 1'b1, 1'b1, 1'b0});
`endif
    exp_q.push_back({1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1});

    cyc = 0; sent = 0; got = 0; held = 1'b0; snap = '0;
    while (got < 8 && cyc < 200) begin
      rdy_in = !(cyc >= 6 && cyc <= 8);
      vin[0] = (sent < 8);
      if (sent < 8) begin
        a = op_a[sent]; b = op_b[sent]; sub = op_sub[sent];
      end
      @(negedge clk);
      cur = {ov[0], s[0], co[0], ovf[0], z[0], n[0]};
      if (held) check("stream_hold", 64'(cur), 64'(snap));
      held = 1'b0;
      if (ov[0]) begin
        if (rdy_in) begin
          check($sformatf("stream_op%0d", got), 64'(cur), 64'(exp_q.pop_front()));
          got++;
        end else begin
          check("stream_stall_ready", 64'(rdy[0]), 64'd0);
          snap = cur;
          held = 1'b1;
        end
      end
      if (vin[0] && rdy[0]) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    vin[0] = 1'b0;
    rdy_in = 1'b1;
    check("stream_count", 64'(got), 64'd8);
    check("stream_sent", 64'(sent), 64'd8);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    check("stream_no_dup", 64'(seen), 64'd0);

    // ---- flush with 3 in flight and a 4th offered ----
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 1); b = 32'd1; sub = 1'b0; vin[0] = 1'b1;
      @(posedge clk); #1;
    end
    a = 32'd50; b = 32'd1; flush = 1'b1; vin[0] = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; vin[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0]) seen++;
      @(posedge clk); #1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op(0, "post_flush", 32'd9, 32'd6, 1'b0, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0);

    // ---- async reset mid-stream ----
    for (int i = 0; i < 5; i++) begin
      a = 32'hFFFF_0000 + 32'(i); b = 32'd1; sub = 1'b1; vin[0] = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_reset_valid", 64'(ov[0]), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(ov[0]), 64'd0);
    check("async_rst_out", 64'({s[0], co[0], ovf[0], z[0], n[0]}), 64'd0);
    check("async_rst_ready", 64'(rdy[0]), 64'd1);
    vin[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 64'(ov[0]), 64'd0);
    run_op(0, "post_reset", 32'd5, 32'd3, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
